// File: rtl/recir_idle_lanes.sv
// Idle-lane recirculation stage: qualified beats go to the mux path, the rest
// are idle-filtered and queued in an FWFT FIFO for the tester.
module recir_idle_lanes #(
  parameter int               LANES    = 4,
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] IDLE_SYM = 8'hBC,
  parameter int               DEPTH    = 4,
  parameter int               QUAL_CYC = 2,
  parameter int               CNT_W    = 8
) (
  input  logic                     clk4f,
  input  logic                     reset,
  input  logic                     valido,
  input  logic [LANES*WIDTH-1:0]   in_data,
  input  logic [LANES-1:0]         valid_in,
  output logic [LANES*WIDTH-1:0]   out_m,
  output logic [LANES-1:0]         valid_outm,
  output logic [LANES*WIDTH-1:0]   out_t,
  output logic [LANES-1:0]         valid_outt,
  output logic                     t_valid,
  input  logic                     t_ready,
  output logic                     fifo_full,
  output logic [1:0]               link_state,
  output logic [CNT_W-1:0]         drop_count,
  output logic [CNT_W-1:0]         idle_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = LANES * WIDTH;
  localparam int EW = LANES + DW;
  localparam int QW = $clog2(QUAL_CYC + 1);

  typedef enum logic [1:0] {
    DOWN = 2'd0,
    QUAL = 2'd1,
    UP   = 2'd2
  } state_t;

  state_t              r_state;
  logic [QW-1:0]       r_qualCnt;
  logic [DW-1:0]       r_outM;
  logic [LANES-1:0]    r_validOutM;
  logic [EW-1:0]       r_mem [DEPTH];
  logic [AW:0]         r_wrPtr;
  logic [AW:0]         r_rdPtr;
  logic [CNT_W-1:0]    r_dropCnt;
  logic [CNT_W-1:0]    r_idleCnt;

  logic [QW-1:0]       w_qualNext;
  logic                w_toMux;
  logic                w_allIdle;
  logic                w_isIdle;
  logic                w_pushReq;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_empty;
  logic                w_full;
  logic [EW-1:0]       w_head;

  assign w_qualNext = r_qualCnt + QW'(1);
  assign w_toMux    = (r_state == UP) && valido;

  always_ff @(posedge clk4f or negedge reset) begin
    if (!reset) begin
      r_state   <= DOWN;
      r_qualCnt <= '0;
    end else begin
      case (r_state)
        DOWN: begin
          if (valido) begin
            r_state   <= (QUAL_CYC == 1) ? UP : QUAL;
            r_qualCnt <= QW'(1);
          end
        end
        QUAL: begin
          if (!valido) begin
            r_state   <= DOWN;
            r_qualCnt <= '0;
          end else begin
            r_qualCnt <= w_qualNext;
            if (w_qualNext == QW'(QUAL_CYC)) r_state <= UP;
          end
        end
        UP: begin
          if (!valido) begin
            r_state   <= DOWN;
            r_qualCnt <= '0;
          end
        end
        default: begin
          r_state   <= DOWN;
          r_qualCnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk4f or negedge reset) begin
    if (!reset) begin
      r_outM      <= '0;
      r_validOutM <= '0;
    end else if (w_toMux) begin
      r_outM      <= in_data;
      r_validOutM <= valid_in;
    end else begin
      r_outM      <= '0;
      r_validOutM <= '0;
    end
  end

  // Lanes whose valid bit is low do not disqualify a beat from being idle.
  always_comb begin
    w_allIdle = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (valid_in[i] && (in_data[i*WIDTH +: WIDTH] != IDLE_SYM)) w_allIdle = 1'b0;
    end
  end

  assign w_isIdle  = (|valid_in) && w_allIdle;
  assign w_pushReq = !w_toMux && (|valid_in) && !w_allIdle;

  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_pop   = !w_empty && t_ready;
  assign w_push  = w_pushReq && (!w_full || w_pop);
  assign w_drop  = w_pushReq && w_full && !w_pop;
  assign w_head  = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk4f) begin
    if (w_push) r_mem[r_wrPtr[AW-1:0]] <= {valid_in, in_data};
  end

  always_ff @(posedge clk4f or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk4f or negedge reset) begin
    if (!reset) begin
      r_dropCnt <= '0;
      r_idleCnt <= '0;
    end else begin
      if (w_drop && (r_dropCnt != '1)) r_dropCnt <= r_dropCnt + 1'b1;
      if (!w_toMux && w_isIdle && (r_idleCnt != '1)) r_idleCnt <= r_idleCnt + 1'b1;
    end
  end

  assign out_m      = r_outM;
  assign valid_outm = r_validOutM;
  assign out_t      = w_empty ? '0 : w_head[DW-1:0];
  assign valid_outt = w_empty ? '0 : w_head[EW-1 -: LANES];
  assign t_valid    = !w_empty;
  assign fifo_full  = w_full;
  assign link_state = r_state;
  assign drop_count = r_dropCnt;
  assign idle_count = r_idleCnt;

endmodule

// File: tb/tb_recir_idle_lanes.sv
// Scoreboard bench for recir_idle_lanes; a second instance with 2-bit counters
// shares the stimulus to exercise counter saturation.
module tb_recir_idle_lanes;

  logic        clk4f = 1'b0;
  logic        reset;
  logic        valido;
  logic [31:0] in_data;
  logic [3:0]  valid_in;
  logic        t_ready;

  logic [31:0] out_m, out_t, out_m2, out_t2;
  logic [3:0]  valid_outm, valid_outt, valid_outm2, valid_outt2;
  logic        t_valid, fifo_full, t_valid2, fifo_full2;
  logic [1:0]  link_state, link_state2;
  logic [7:0]  drop_count, idle_count;
  logic [1:0]  drop_count2, idle_count2;

  int total = 0;
  int bad   = 0;
  logic [35:0] tq[$];
  logic [35:0] mq[$];

  always #5 clk4f = ~clk4f;

  recir_idle_lanes #(.LANES(4), .WIDTH(8), .IDLE_SYM(8'hBC), .DEPTH(4), .QUAL_CYC(2), .CNT_W(8)) dut (
    .clk4f(clk4f), .reset(reset), .valido(valido), .in_data(in_data), .valid_in(valid_in),
    .out_m(out_m), .valid_outm(valid_outm), .out_t(out_t), .valid_outt(valid_outt),
    .t_valid(t_valid), .t_ready(t_ready), .fifo_full(fifo_full), .link_state(link_state),
    .drop_count(drop_count), .idle_count(idle_count)
  );

  recir_idle_lanes #(.LANES(4), .WIDTH(8), .IDLE_SYM(8'hBC), .DEPTH(4), .QUAL_CYC(2), .CNT_W(2)) dutSat (
    .clk4f(clk4f), .reset(reset), .valido(valido), .in_data(in_data), .valid_in(valid_in),
    .out_m(out_m2), .valid_outm(valid_outm2), .out_t(out_t2), .valid_outt(valid_outt2),
    .t_valid(t_valid2), .t_ready(t_ready), .fifo_full(fifo_full2), .link_state(link_state2),
    .drop_count(drop_count2), .idle_count(idle_count2)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one beat, record its expected destination, then advance past the edge.
  task automatic applyStimulus(input logic vo, input logic [31:0] d, input logic [3:0] v,
                               input logic tr, input bit toT, input bit toM);
    valido   = vo;
    in_data  = d;
    valid_in = v;
    t_ready  = tr;
    if (toT) tq.push_back({v, d});
    if (toM) mq.push_back({v, d});
    @(posedge clk4f);
    #1;
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectations.
  always @(negedge clk4f) begin
    if (reset) begin
      if (t_valid && t_ready) begin
        if (tq.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL tHeadUnexpected: got %0h expected nothing", {valid_outt, out_t});
        end else begin
          checkOutput("tHead", {valid_outt, out_t}, tq.pop_front());
        end
      end
      if (valid_outm != 4'h0) begin
        if (mq.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL muxUnexpected: got %0h expected nothing", {valid_outm, out_m});
        end else begin
          checkOutput("muxOut", {valid_outm, out_m}, mq.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b0; valido = 1'b0; in_data = '0; valid_in = '0; t_ready = 1'b0;
    #2;
    checkOutput("rstOutM", {valid_outm, out_m}, 0);
    checkOutput("rstOutT", {valid_outt, out_t}, 0);
    checkOutput("rstFlags", {t_valid, fifo_full, link_state}, 0);
    checkOutput("rstCounts", {drop_count, idle_count}, 0);
    #10 reset = 1'b1;
    @(posedge clk4f); #1;

    // Reset mid-stream discards queued entries
    applyStimulus(0, 32'h01020304, 4'hF, 0, 0, 0);
    applyStimulus(0, 32'h05060708, 4'hF, 0, 0, 0);
    applyStimulus(0, 32'h090A0B0C, 4'hF, 0, 0, 0);
    checkOutput("preRstHead", {t_valid, valid_outt, out_t}, {1'b1, 4'hF, 32'h01020304});
    valid_in = '0;
    #3 reset = 1'b0;
    #1;
    checkOutput("midRstOutT", {t_valid, fifo_full, valid_outt, out_t}, 0);
    checkOutput("midRstLink", link_state, 0);
    #1 reset = 1'b1;
    @(posedge clk4f); #1;
    applyStimulus(0, 32'h0, 4'h0, 1, 0, 0);
    checkOutput("noRecover", t_valid, 0);

    // Qualification
    applyStimulus(1, 32'h11223344, 4'hF, 1, 1, 0);
    checkOutput("qual1", link_state, 1);
    applyStimulus(0, 32'h11223344, 4'hF, 1, 1, 0);
    checkOutput("qualDrop", link_state, 0);
    applyStimulus(1, 32'h11223344, 4'hF, 1, 1, 0);
    checkOutput("qual2a", link_state, 1);
    applyStimulus(1, 32'h11223344, 4'hF, 1, 1, 0);
    checkOutput("qual2b", link_state, 2);
    applyStimulus(1, 32'h11223344, 4'hF, 1, 0, 1);
    checkOutput("firstMux", {valid_outm, out_m}, {4'hF, 32'h11223344});
    applyStimulus(0, 32'h55667788, 4'hF, 1, 1, 0);
    checkOutput("fallLink", link_state, 0);
    checkOutput("fallOutM", {valid_outm, out_m}, 0);
    applyStimulus(0, 32'h0, 4'h0, 1, 0, 0);
    applyStimulus(0, 32'h0, 4'h0, 1, 0, 0);

    // Idle filtering
    for (int i = 0; i < 5; i++) applyStimulus(0, 32'hBCBCBCBC, 4'hF, 1, 0, 0);
    applyStimulus(0, 32'hBC00BCBC, 4'b1011, 1, 0, 0);
    checkOutput("idleCount", idle_count, 6);
    checkOutput("idleSat", idle_count2, 3);
    checkOutput("idleNoPush", t_valid, 0);
    applyStimulus(0, 32'h0000BC01, 4'h3, 0, 1, 0);
    checkOutput("partialPush", {t_valid, valid_outt, out_t}, {1'b1, 4'h3, 32'h0000BC01});
    applyStimulus(0, 32'h0, 4'h0, 1, 0, 0);
    checkOutput("partialDrained", t_valid, 0);

    // Overflow
    for (int k = 1; k <= 6; k++) begin
      logic [7:0] b;
      b = 8'hA0 + 8'(k);
      applyStimulus(0, {4{b}}, 4'hF, 0, k <= 4, 0);
      if (k == 4) checkOutput("fullAfter4", {fifo_full, drop_count}, {1'b1, 8'd0});
    end
    checkOutput("dropCount2", drop_count, 2);
    checkOutput("ovfHead", {fifo_full, out_t}, {1'b1, 32'hA1A1A1A1});

    // Full with simultaneous push and pop
    applyStimulus(0, 32'hB1B2B3B4, 4'hF, 1, 1, 0);
    checkOutput("pushPopFull", {fifo_full, drop_count}, {1'b1, 8'd2});
    checkOutput("pushPopHead", out_t, 32'hA2A2A2A2);
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 4'h0, 1, 0, 0);
    checkOutput("drainedAll", {t_valid, fifo_full}, 0);

    // Saturation, then drain during UP
    for (int k = 1; k <= 9; k++) begin
      logic [7:0] b;
      b = 8'hC0 + 8'(k);
      applyStimulus(0, {4{b}}, 4'hF, 0, k <= 4, 0);
    end
    checkOutput("dropMain", drop_count, 7);
    checkOutput("dropSat", drop_count2, 3);
    applyStimulus(0, 32'h0, 4'h0, 1, 0, 0);
    applyStimulus(0, 32'h0, 4'h0, 1, 0, 0);
    checkOutput("twoQueued", {t_valid, fifo_full, out_t}, {1'b1, 1'b0, 32'hC3C3C3C3});
    applyStimulus(1, 32'h0, 4'h0, 0, 0, 0);
    applyStimulus(1, 32'h0, 4'h0, 0, 0, 0);
    checkOutput("upAgain", link_state, 2);
    applyStimulus(1, 32'hE1E2E3E4, 4'hF, 1, 0, 1);
    checkOutput("upMux1", out_m, 32'hE1E2E3E4);
    checkOutput("upTester1", {t_valid, out_t}, {1'b1, 32'hC4C4C4C4});
    applyStimulus(1, 32'hF1F2F3F4, 4'h5, 1, 0, 1);
    checkOutput("upMux2", {valid_outm, out_m}, {4'h5, 32'hF1F2F3F4});
    checkOutput("upTester2", t_valid, 0);
    applyStimulus(0, 32'h0, 4'h0, 0, 0, 0);
    applyStimulus(0, 32'h0, 4'h0, 0, 0, 0);
    checkOutput("tqEmpty", tq.size(), 0);
    checkOutput("mqEmpty", mq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
